// File: rtl/iq_power_meter.sv
// I/Q power meter: three-stage pipeline (squares, sum, windowed accumulate)
// producing the mean of I^2+Q^2 over 2^window_log2_i accepted samples.
module iq_power_meter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2   = 10
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               en_i,
  input  logic                               clear_i,
  input  logic [$clog2(MAX_LOG2+1)-1:0]      window_log2_i,
  input  logic                               tvalid_i,
  input  logic [1:0][DATA_WIDTH-1:0]         tdata_i,
  output logic                               tvalid_o,
  output logic [2*DATA_WIDTH-1:0]            tdata_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + MAX_LOG2;
  localparam int LW = $clog2(MAX_LOG2 + 1);
  localparam int CW = MAX_LOG2 + 1;

  // input side: window tracking
  logic [CW-1:0]        r_cnt;
  logic [LW-1:0]        r_log2;
  logic [LW-1:0]        w_log2_clamp;
  logic [LW-1:0]        w_log2_eff;
  logic [CW-1:0]        w_cnt_max;
  logic                 w_last;
  logic                 w_accept;

  // pipeline
  logic signed [PW-1:0] w_i_ext;
  logic signed [PW-1:0] w_q_ext;
  logic [PW-1:0]        w_ii;
  logic [PW-1:0]        w_qq;
  logic [PW-1:0]        r_ii;
  logic [PW-1:0]        r_qq;
  logic                 r_v1;
  logic                 r_last1;
  logic [LW-1:0]        r_sh1;
  logic [PW-1:0]        r_p;
  logic                 r_v2;
  logic                 r_last2;
  logic [LW-1:0]        r_sh2;
  logic [AW-1:0]        r_acc;
  logic [AW-1:0]        w_sum;
  logic                 r_tvalid_o;
  logic [PW-1:0]        r_tdata_o;

  assign w_log2_clamp = (window_log2_i > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : window_log2_i;
  // The first sample of a window uses the live setting; later ones the captured copy.
  assign w_log2_eff   = (r_cnt == '0) ? w_log2_clamp : r_log2;
  assign w_cnt_max    = (CW'(1) << w_log2_eff) - CW'(1);
  assign w_last       = (r_cnt == w_cnt_max);
  assign w_accept     = en_i & ~clear_i & tvalid_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt  <= '0;
      r_log2 <= '0;
    end else if (en_i) begin
      if (clear_i) begin
        r_cnt <= '0;
      end else if (tvalid_i) begin
        if (r_cnt == '0) r_log2 <= w_log2_clamp;
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

  // Sign-extend first so the full-width product is exact and non-negative.
  assign w_i_ext = PW'($signed(tdata_i[0]));
  assign w_q_ext = PW'($signed(tdata_i[1]));
  assign w_ii    = $unsigned(w_i_ext * w_i_ext);
  assign w_qq    = $unsigned(w_q_ext * w_q_ext);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_v1    <= 1'b0;
      r_ii    <= '0;
      r_qq    <= '0;
      r_last1 <= 1'b0;
      r_sh1   <= '0;
    end else if (en_i) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_ii    <= w_ii;
        r_qq    <= w_qq;
        r_last1 <= w_last;
        r_sh1   <= w_log2_eff;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_v2    <= 1'b0;
      r_p     <= '0;
      r_last2 <= 1'b0;
      r_sh2   <= '0;
    end else if (en_i) begin
      r_v2 <= r_v1 & ~clear_i;
      if (r_v1 && !clear_i) begin
        r_p     <= r_ii + r_qq;
        r_last2 <= r_last1;
        r_sh2   <= r_sh1;
      end
    end
  end

  assign w_sum = r_acc + AW'(r_p);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc      <= '0;
      r_tvalid_o <= 1'b0;
      r_tdata_o  <= '0;
    end else if (en_i) begin
      r_tvalid_o <= 1'b0;
      if (clear_i) begin
        r_acc <= '0;
      end else if (r_v2) begin
        if (r_last2) begin
          r_tdata_o  <= PW'(w_sum >> r_sh2);
          r_tvalid_o <= 1'b1;
          r_acc      <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  // A pulse frozen by en_i low is shown once enable returns; clear suppresses it.
  assign tvalid_o = r_tvalid_o & en_i & ~clear_i;
  assign tdata_o  = r_tdata_o;

endmodule

// File: tb/tb_iq_power_meter.sv
// Directed bench for iq_power_meter: vector table for per-sample power plus
// hand-written sequences for windowing, gaps, enable, clear and reset.
module tb_iq_power_meter;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              en_i;
  logic              clear_i;
  logic [3:0]        window_log2_i;
  logic              tvalid_i;
  logic [1:0][15:0]  tdata_i;
  logic              tvalid_o;
  logic [31:0]       tdata_o;

  iq_power_meter #(.DATA_WIDTH(16), .MAX_LOG2(10)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .en_i          (en_i),
    .clear_i       (clear_i),
    .window_log2_i (window_log2_i),
    .tvalid_i      (tvalid_i),
    .tdata_i       (tdata_i),
    .tvalid_o      (tvalid_o),
    .tdata_o       (tdata_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [31:0]        exp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } pulse_t;

  int     cyc = 0;
  int     last_cyc;
  int     errors = 0;
  int     checks = 0;
  int     en_low_pulses = 0;
  pulse_t pq[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (tvalid_o) begin
      pq.push_back('{cyc: cyc, data: tdata_o});
      $display("pulse cyc=%0d tdata_o=%0d", cyc, tdata_o);
      if (!en_i) en_low_pulses++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pulse(input string name, input int idx, input int exp_cyc,
                           input logic [31:0] exp_data);
    chk({name, "_present"}, longint'(pq.size() > idx), 1);
    if (pq.size() > idx) begin
      chk({name, "_data"}, pq[idx].data, exp_data);
      chk({name, "_cyc"}, pq[idx].cyc, exp_cyc);
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic v,
                       input logic signed [15:0] i, input logic signed [15:0] q,
                       input logic [3:0] wl);
    en_i          = en;
    clear_i       = clr;
    tvalid_i      = v;
    tdata_i[0]    = i;
    tdata_i[1]    = q;
    window_log2_i = wl;
    last_cyc      = cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] wl);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, wl);
  endtask

  task automatic restart();
    drive(1'b1, 1'b1, 1'b0, 16'sd0, 16'sd0, 4'd0);
    idle(3, 4'd0);
    pq.delete();
  endtask

  vec_t vecs[7];
  int   sc[16];
  int   s1024;
  int   s2048;

  initial begin
    vecs[0] = '{i:  16'sd3,      q: -16'sd4,     exp: 32'd25};
    vecs[1] = '{i:  16'sd0,      q:  16'sd0,     exp: 32'd0};
    vecs[2] = '{i: -16'sd5,      q:  16'sd12,    exp: 32'd169};
    vecs[3] = '{i: -16'sd32768,  q: -16'sd32768, exp: 32'd2147483648};
    vecs[4] = '{i:  16'sd32767,  q:  16'sd0,     exp: 32'd1073676289};
    vecs[5] = '{i:  16'sd1,      q:  16'sd1,     exp: 32'd2};
    vecs[6] = '{i:  16'sd0,      q: -16'sd1,     exp: 32'd1};

    // reset held with random traffic
    rstn_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      en_i          = 1'b1;
      clear_i       = 1'b0;
      tvalid_i      = 1'($urandom_range(0, 1));
      tdata_i[0]    = 16'($urandom);
      tdata_i[1]    = 16'($urandom);
      window_log2_i = 4'($urandom_range(0, 10));
      @(negedge clk_i);
      chk("reset_tvalid", tvalid_o, 0);
      chk("reset_tdata", tdata_o, 0);
      @(posedge clk_i);
      #1;
    end
    rstn_i = 1'b1;
    restart();

    // window of one sample: every sample's power, latency 3
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, 1'b1, vecs[k].i, vecs[k].q, 4'd0);
      sc[k] = last_cyc;
    end
    idle(5, 4'd0);
    chk("w0_count", pq.size(), 7);
    for (int k = 0; k < 7; k++) chk_pulse($sformatf("w0_vec%0d", k), k, sc[k] + 3, vecs[k].exp);

    // constant 1000 over window of 4
    restart();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, 1'b1, 16'sd1000, 16'sd0, 4'd2);
      sc[k] = last_cyc;
    end
    idle(5, 4'd2);
    chk("w2_count", pq.size(), 3);
    for (int k = 0; k < 3; k++) chk_pulse($sformatf("w2_p%0d", k), k, sc[4*k+3] + 3, 32'd1000000);
    chk("hold_tvalid", tvalid_o, 0);
    chk("hold_tdata", tdata_o, 1000000);

    // full-scale over 1024, then a clamped setting of 15
    restart();
    for (int k = 0; k < 2048; k++) begin
      drive(1'b1, 1'b0, 1'b1, -16'sd32768, -16'sd32768, (k < 1024) ? 4'd10 : 4'd15);
      if (k == 1023) s1024 = last_cyc;
      if (k == 2047) s2048 = last_cyc;
    end
    idle(5, 4'd10);
    chk("fs_count", pq.size(), 2);
    chk_pulse("fs_p0", 0, s1024 + 3, 32'd2147483648);
    chk_pulse("fs_clamp_p1", 1, s2048 + 3, 32'd2147483648);

    // gapped input plus enable low with a window-closing sample in flight
    restart();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b1, 16'sd100, 16'sd100, 4'd2);
      if (k == 3) begin
        for (int e = 0; e < 5; e++) drive(1'b0, 1'b0, 1'b1, 16'sd7, 16'sd7, 4'd2);
      end
      idle(2, 4'd2);
    end
    idle(5, 4'd2);
    chk("gap_count", pq.size(), 2);
    chk("gap_p0", (pq.size() > 0) ? pq[0].data : 0, 20000);
    chk("gap_p1", (pq.size() > 1) ? pq[1].data : 0, 20000);
    chk("en_low_pulses", en_low_pulses, 0);

    // clear mid-window, then window change mid-window
    restart();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b1, 16'sd10, 16'sd0, 4'd3);
    drive(1'b1, 1'b1, 1'b1, 16'sd999, 16'sd0, 4'd3);
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, 1'b1, 16'sd20, 16'sd0, (k < 2) ? 4'd3 : 4'd1);
      sc[k] = last_cyc;
    end
    idle(5, 4'd1);
    chk("clr_count", pq.size(), 3);
    chk_pulse("clr_p0", 0, sc[7] + 3, 32'd400);
    chk_pulse("clr_p1", 1, sc[9] + 3, 32'd400);
    chk_pulse("clr_p2", 2, sc[11] + 3, 32'd400);

    // asynchronous reset in the middle of a window
    restart();
    for (int k = 0; k < 2; k++) drive(1'b1, 1'b0, 1'b1, 16'sd50, 16'sd0, 4'd2);
    rstn_i = 1'b0;
    #2;
    chk("async_rst_tvalid", tvalid_o, 0);
    chk("async_rst_tdata", tdata_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 16'sd30, 16'sd0, 4'd2);
      sc[k] = last_cyc;
    end
    idle(5, 4'd2);
    chk("rst_count", pq.size(), 1);
    chk_pulse("rst_p0", 0, sc[3] + 3, 32'd900);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
